i2s_audio_capture: RTL and testbench
====================================

// Module: i2s_audio_capture
// PURPOSE
//  Captures the WonderSwan Color I2S audio stream (BCLK/LRCK/SDAT) in the pixel clock domain.
//  Assembles left/right PCM words into stereo pairs and buffers them in a small FIFO.
//  Sits between the cartridge-side audio pins and the HDMI audio packetiser in imageGen.
//  The packetiser pops pairs with a valid/ready handshake.
// PARAMETERS
//  SAMPLE_W       16  PCM word width in bits; MSB-first, left-justified capture
//  FIFO_DEPTH     4   stereo-pair FIFO entries (power of two, >=2)
//  RATE_WIN_LOG2  10  log2 of stereo pairs per rate-measurement window (AUDIO_RATE_MEAS_EN only)
// PORTS
//  clk          in   1           pixel clock (pxlClk); all logic on rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  bclk         in   1           I2S bit clock, async to clk, <= clk/4
//  lrck         in   1           I2S word select, async; 0 = left, 1 = right
//  sdat         in   1           I2S serial data, async
//  aud_valid    out  1           FIFO head holds a stereo pair
//  aud_ready    in   1           consumer accepts head when aud_valid & aud_ready
//  aud_l        out  SAMPLE_W    left sample at FIFO head (two's complement)
//  aud_r        out  SAMPLE_W    right sample at FIFO head
//  aud_ovf      out  1           1-cycle pulse: completed pair dropped, FIFO full
//  rate_cycles  out  24          clk cycles per 2^RATE_WIN_LOG2 pairs (macro only, else 0)
//  rate_upd     out  1           1-cycle pulse when rate_cycles updates (macro only, else 0)
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; shift reg, bit count, pending-left flag cleared.
//    rst_n low mid-word discards the partial word and all FIFO contents.
//  - bclk/lrck/sdat each pass through a 2-FF synchroniser plus one history FF.
//    A bit event is a synced bclk 0->1. lrck and sdat are sampled at the same cycle.
//  - Bit event: if bitcnt < SAMPLE_W, shift sdat into the LSB and increment bitcnt.
//    Extra bits beyond SAMPLE_W are ignored; bitcnt saturates at SAMPLE_W.
//  - Word end: sampled lrck != lrck sampled at previous bit event.
//    I2S one-bit delay: the bit taken at this event is still the LSB of the old word.
//    It is shifted in first, then the word closes with channel = previous lrck.
//  - Short word (bitcnt < SAMPLE_W): value = shreg << (SAMPLE_W - bitcnt), zero-padded LSBs.
//    After word close: shreg = 0, bitcnt = 0.
//  - Left word close: store in left holding reg; set pending_l. A second left overwrites the first.
//  - Right word close with pending_l: push {left,right}; clear pending_l.
//    Without pending_l: discard the word (start-up or misalignment).
//  - Push when FIFO full and no pop that cycle: drop the pair; aud_ovf = 1 for one cycle.
//  - Push and pop in the same cycle: both occur, including at full or with count 1.
//    Occupancy is unchanged.
//  - Latency: pair becomes visible (aud_valid=1) one clk after the push cycle.
//    The push cycle is 4 clk after the bclk edge at the pins (2 sync + 1 edge + 1 close).
//  - aud_l/aud_r are registered FIFO-head outputs and hold while aud_valid & ~aud_ready.
//    Values are don't-care while aud_valid = 0.
//  - Pointers: log2(FIFO_DEPTH) bits plus a wrap bit; full = MSBs differ and LSBs equal.
// CONFIGURATION
//  AUDIO_RATE_MEAS_EN defined:
//  - A 24-bit free-running cycle counter and a pair counter run from reset.
//  - On the push that completes 2^RATE_WIN_LOG2 pairs:
//    rate_cycles <= cycle count; rate_upd pulses; both counters restart.
//    The restarted cycle count is 1 for the next cycle.
//  - Dropped pairs count as completed pairs.
//  - Cycle counter saturates at 2^24-1 (no wrap).
//  AUDIO_RATE_MEAS_EN undefined: rate_cycles and rate_upd tied to 0; no counters synthesised.
// TESTING
//  1. Reset, then one I2S frame: L=16'h1234, R=16'hABCD, bclk=clk/8, aud_ready=1.
//     -> one aud_valid pulse, aud_l=1234, aud_r=ABCD.
//  2. Right word first, then L=0001 / R=0002.
//     -> orphan right discarded; exactly one pair {0001,0002}.
//  3. aud_ready=0, send 5 pairs with FIFO_DEPTH=4.
//     -> aud_ovf pulses once (5th pair); then raising ready pops pairs 1..4 in order.
//  4. 12-bit words: L=12'hFFF, R=12'h800.
//     -> aud_l=16'hFFF0, aud_r=16'h8000. 20-bit words -> top 16 bits kept.
//  5. Assert rst_n low midway through a left word, release, send L=5555/R=AAAA.
//     -> all outputs 0 during reset; only {5555,AAAA} emerges.
//  6. AUDIO_RATE_MEAS_EN, RATE_WIN_LOG2=2, one pair every 600 clk.
//     -> rate_upd every 4th push; rate_cycles=2400. Without macro both stay 0.

Source files
------------

// File: rtl/i2s_audio_capture.sv
`default_nettype none
// ============================================================================
// Module   : i2s_audio_capture
// Brief    : I2S (BCLK/LRCK/SDAT) capture into a stereo-pair FIFO with a
//            valid/ready pop port. Optional macro AUDIO_RATE_MEAS_EN adds
//            a sample-rate measurement (rate_cycles/rate_upd).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_audio_capture #(
    parameter int SAMPLE_W      = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int RATE_WIN_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bclk,
    input  logic                lrck,
    input  logic                sdat,
    output logic                aud_valid,
    input  logic                aud_ready,
    output logic [SAMPLE_W-1:0] aud_l,
    output logic [SAMPLE_W-1:0] aud_r,
    output logic                aud_ovf,
    output logic [23:0]         rate_cycles,
    output logic                rate_upd
);

    localparam int C_AW    = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [C_CNT_W-1:0] C_SW = C_CNT_W'(SAMPLE_W);

    logic r_bclk_s1, r_bclk_s2, r_bclk_h;
    logic r_lrck_s1, r_lrck_s2, r_lrck_h;
    logic r_sdat_s1, r_sdat_s2, r_sdat_h;
    logic r_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_s1 <= 1'b0; r_bclk_s2 <= 1'b0; r_bclk_h <= 1'b0;
            r_lrck_s1 <= 1'b0; r_lrck_s2 <= 1'b0; r_lrck_h <= 1'b0;
            r_sdat_s1 <= 1'b0; r_sdat_s2 <= 1'b0; r_sdat_h <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_bclk_s1 <= bclk; r_bclk_s2 <= r_bclk_s1; r_bclk_h <= r_bclk_s2;
            r_lrck_s1 <= lrck; r_lrck_s2 <= r_lrck_s1; r_lrck_h <= r_lrck_s2;
            r_sdat_s1 <= sdat; r_sdat_s2 <= r_sdat_s1; r_sdat_h <= r_sdat_s2;
            // r_lrck_h/r_sdat_h are captured on the same edge, so they align with r_evt
            r_evt     <= r_bclk_s2 & ~r_bclk_h;
        end
    end

    logic [SAMPLE_W-1:0] r_shreg, r_left;
    logic [C_CNT_W-1:0]  r_bitcnt;
    logic                r_last_lrck, r_lr_seen, r_pending_l;

    logic                w_shift_ok, w_word_end, w_push_req;
    logic [SAMPLE_W-1:0] w_shreg_nx, w_word;
    logic [C_CNT_W-1:0]  w_cnt_nx;

    assign w_shift_ok = (r_bitcnt < C_SW);
    assign w_shreg_nx = w_shift_ok ? {r_shreg[SAMPLE_W-2:0], r_sdat_h} : r_shreg;
    assign w_cnt_nx   = w_shift_ok ? r_bitcnt + C_CNT_W'(1) : r_bitcnt;
    // No word boundary until one bit event has established the current channel
    assign w_word_end = r_evt & r_lr_seen & (r_lrck_h != r_last_lrck);
    assign w_word     = w_shreg_nx << (C_SW - w_cnt_nx);
    assign w_push_req = w_word_end & r_last_lrck & r_pending_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_left      <= '0;
            r_bitcnt    <= '0;
            r_last_lrck <= 1'b0;
            r_lr_seen   <= 1'b0;
            r_pending_l <= 1'b0;
        end else if (r_evt) begin
            r_last_lrck <= r_lrck_h;
            r_lr_seen   <= 1'b1;
            if (w_word_end) begin
                r_shreg  <= '0;
                r_bitcnt <= '0;
                if (!r_last_lrck) begin
                    r_left      <= w_word;
                    r_pending_l <= 1'b1;
                end else begin
                    r_pending_l <= 1'b0;
                end
            end else begin
                r_shreg  <= w_shreg_nx;
                r_bitcnt <= w_cnt_nx;
            end
        end
    end

    logic [SAMPLE_W-1:0] r_mem_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] r_mem_r [FIFO_DEPTH];
    logic [C_AW:0]       r_wptr, r_rptr;
    logic                r_ovf;
    logic                w_full, w_empty, w_pop, w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                     (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
    assign w_pop   = ~w_empty & aud_ready;
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_l[i] <= '0;
                r_mem_r[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_l[r_wptr[C_AW-1:0]] <= r_left;
                r_mem_r[r_wptr[C_AW-1:0]] <= w_word;
                r_wptr <= r_wptr + (C_AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (C_AW+1)'(1);
            end
            r_ovf <= w_push_req & w_full & ~w_pop;
        end
    end

    assign aud_valid = ~w_empty;
    assign aud_l     = r_mem_l[r_rptr[C_AW-1:0]];
    assign aud_r     = r_mem_r[r_rptr[C_AW-1:0]];
    assign aud_ovf   = r_ovf;

`ifdef AUDIO_RATE_MEAS_EN
    localparam logic [23:0] C_CYC_MAX = '1;

    logic [23:0]              r_cyc, r_rate;
    logic [RATE_WIN_LOG2-1:0] r_pairs;
    logic                     r_upd;
    logic                     w_win_done;

    // Dropped pairs still close a window: the count tracks the source rate
    assign w_win_done = w_push_req & (&r_pairs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc   <= '0;
            r_rate  <= '0;
            r_pairs <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            if (w_win_done) begin
                r_rate  <= r_cyc;
                r_upd   <= 1'b1;
                r_cyc   <= 24'd1;
                r_pairs <= '0;
            end else begin
                if (r_cyc != C_CYC_MAX) begin
                    r_cyc <= r_cyc + 24'd1;
                end
                if (w_push_req) begin
                    r_pairs <= r_pairs + RATE_WIN_LOG2'(1);
                end
            end
        end
    end

    assign rate_cycles = r_rate;
    assign rate_upd    = r_upd;
`else
    assign rate_cycles = 24'd0;
    assign rate_upd    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2s_audio_capture
// Brief    : Scoreboard bench for i2s_audio_capture (bclk = clk/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_audio_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk = 1'b0;
    logic        lrck = 1'b0;
    logic        sdat = 1'b0;
    logic        aud_ready = 1'b0;
    logic        aud_valid;
    logic [15:0] aud_l, aud_r;
    logic        aud_ovf;
    logic [23:0] rate_cycles;
    logic        rate_upd;

    always #5 clk = ~clk;

    i2s_audio_capture #(
        .SAMPLE_W      (16),
        .FIFO_DEPTH    (4),
        .RATE_WIN_LOG2 (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bclk        (bclk),
        .lrck        (lrck),
        .sdat        (sdat),
        .aud_valid   (aud_valid),
        .aud_ready   (aud_ready),
        .aud_l       (aud_l),
        .aud_r       (aud_r),
        .aud_ovf     (aud_ovf),
        .rate_cycles (rate_cycles),
        .rate_upd    (rate_upd)
    );

    int          checks = 0;
    int          errors = 0;
    int          ovf_cnt = 0;
    int          upd_cnt = 0;
    logic [23:0] last_rate = '0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted pair
    always @(negedge clk) begin
        if (rst_n) begin
            if (aud_valid && aud_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got %h expected none", {aud_l, aud_r});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pair", {aud_l, aud_r}, mon_exp);
                end
            end
            if (aud_ovf) ovf_cnt++;
            if (rate_upd) begin
                upd_cnt++;
                last_rate = rate_cycles;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic l, input logic d);
        lrck = l;
        sdat = d;
        tick(4);
        bclk = 1'b1;
        tick(4);
        bclk = 1'b0;
    endtask

    // LSB goes out with the next channel's lrck (I2S one-bit delay)
    task automatic send_word(input logic ch, input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 1; i--) send_bit(ch, val[i]);
        send_bit(~ch, val[0]);
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int n,
                             input logic expect_it, input logic [31:0] exp_pair);
        if (expect_it) exp_q.push_back(exp_pair);
        send_word(1'b0, l, n);
        send_word(1'b1, r, n);
    endtask

    task automatic reset_dut(input logic chk);
        rst_n = 1'b0;
        bclk  = 1'b0;
        lrck  = 1'b0;
        sdat  = 1'b0;
        exp_q.delete();
        tick(3);
        if (chk) begin
            check("rst_valid", {31'd0, aud_valid}, 32'd0);
            check("rst_l", {16'd0, aud_l}, 32'd0);
            check("rst_r", {16'd0, aud_r}, 32'd0);
            check("rst_ovf", {31'd0, aud_ovf}, 32'd0);
            check("rst_rate_cycles", {8'd0, rate_cycles}, 32'd0);
            check("rst_rate_upd", {31'd0, rate_upd}, 32'd0);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic drain(input int n);
        tick(n);
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aud_ready = 1'b1;
        tick(2);
        reset_dut(1'b1);

        // Single frame
        send_pair(32'h1234, 32'hABCD, 16, 1'b1, 32'h1234ABCD);
        drain(20);

        // Orphan right word after reset is discarded
        reset_dut(1'b0);
        send_word(1'b1, 32'h7777, 16);
        send_pair(32'h0001, 32'h0002, 16, 1'b1, 32'h00010002);
        drain(20);

        // Overflow on the fifth pair while the consumer stalls
        ovf_cnt   = 0;
        aud_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_pair(32'h1000 + i, 32'h2000 + i, 16, (i < 4), {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
        tick(20);
        check("ovf_count", ovf_cnt, 32'd1);
        check("hold_valid", {31'd0, aud_valid}, 32'd1);
        check("hold_head", {aud_l, aud_r}, 32'h10002000);
        aud_ready = 1'b1;
        drain(20);

        // Short and long words
        send_pair(32'hFFF, 32'h800, 12, 1'b1, 32'hFFF08000);
        send_pair(32'h12345, 32'hFEDCB, 20, 1'b1, 32'h1234FEDC);
        drain(20);

        // Reset mid-word with a pair already buffered
        aud_ready = 1'b0;
        send_pair(32'h0BAD, 32'hF00D, 16, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) send_bit(1'b0, i[0]);
        tick(10);
        check("pre_reset_valid", {31'd0, aud_valid}, 32'd1);
        reset_dut(1'b1);
        aud_ready = 1'b1;
        send_pair(32'h5555, 32'hAAAA, 16, 1'b1, 32'h5555AAAA);
        drain(20);

        // One pair every 600 clk (256 clk of bits + 344 idle)
        reset_dut(1'b0);
        upd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            send_pair(32'h0100 + k, 32'h0200 + k, 16, 1'b1, {16'h0100 + 16'(k), 16'h0200 + 16'(k)});
            tick(344);
        end
`ifdef AUDIO_RATE_MEAS_EN
        check("rate_upd_count", upd_cnt, 32'd2);
        check("rate_cycles", {8'd0, last_rate}, 32'd2400);
`else
        check("rate_upd_count", upd_cnt, 32'd0);
        check("rate_cycles", {8'd0, rate_cycles}, 32'd0);
`endif
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
